// File: rtl/mem_qos_arb_pkg.sv
// rtl/mem_qos_arb_pkg.sv - shared types, constants and sizing helpers for the QoS memory arbiter
package mem_qos_arb_pkg;

  typedef logic [3:0] qos_t;

  localparam int QOS_AGED = 16;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int out_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mem_qos_arb_fifo.sv
// rtl/mem_qos_arb_fifo.sv - per-channel request FIFO, head visible combinationally
module mem_qos_arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty; wrap is the natural overflow.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_qos_arb.sv
// rtl/mem_qos_arb.sv - QoS arbiter with outstanding limits; MEM_QOS_ARB_AGING_EN enables starvation aging
module mem_qos_arb
  import mem_qos_arb_pkg::*;
#(
  parameter int  ADDR_W  = 48,
  parameter int  DATA_W  = 256,
  parameter int  NCH     = 4,
  parameter int  DEPTH   = 8,
  parameter int  MAX_OUT = 16,
  parameter int  AGE_TH  = 64,
  localparam int CH_W    = ch_w(NCH),
  localparam int OUT_W   = out_w(MAX_OUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH-1:0]        req_write,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  input  logic [NCH*4-1:0]      req_qos,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [CH_W-1:0]       mem_tag,
  input  logic                  mem_resp_valid,
  input  logic [CH_W-1:0]       mem_resp_tag,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic                  mem_resp_ready,
  output logic [NCH-1:0]        resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  input  logic [NCH-1:0]        resp_ready,
  output logic [NCH*OUT_W-1:0]  outstanding,
  output logic                  resp_err
);

  localparam int EW      = ADDR_W + 1 + DATA_W + 4;
  localparam int QOS_LSB = ADDR_W + DATA_W + 1;
  localparam int EQ_W    = $clog2(QOS_AGED + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AGE_TH < 1) begin : g_bad_params
    $error("mem_qos_arb: DEPTH must be a power of 2 >= 2 and AGE_TH >= 1");
  end

  logic [NCH-1:0]   f_full;
  logic [NCH-1:0]   f_empty;
  logic [NCH-1:0]   f_pop;
  logic [NCH-1:0]   elig;
  logic [EW-1:0]    f_head [NCH];
  logic [OUT_W-1:0] out_cnt [NCH];
  logic [EQ_W-1:0]  eff_q [NCH];
  logic [CH_W-1:0]  rr_last;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  idx;
  logic [EQ_W-1:0]  best;
  logic             any_elig;
  logic             load;
  logic             tag_ok;
  logic             tag_live;
  logic             resp_hs;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    qos_t head_qos;
    logic dec;

    mem_qos_arb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid[c] && req_ready[c]),
      .push_data ({req_qos[c*4 +: 4], req_write[c], req_wdata[c*DATA_W +: DATA_W],
                   req_addr[c*ADDR_W +: ADDR_W]}),
      .pop       (f_pop[c]),
      .full      (f_full[c]),
      .empty     (f_empty[c]),
      .head      (f_head[c])
    );

    assign req_ready[c] = !rst && !f_full[c];
    assign head_qos     = f_head[c][QOS_LSB +: 4];
    assign elig[c]      = !f_empty[c] && (out_cnt[c] < OUT_W'(MAX_OUT));
    assign f_pop[c]     = load && (grant == CH_W'(c));
    assign resp_valid[c] = mem_resp_valid && (mem_resp_tag == CH_W'(c));
    assign dec = resp_hs && (mem_resp_tag == CH_W'(c)) && (out_cnt[c] != '0);
    assign outstanding[c*OUT_W +: OUT_W] = out_cnt[c];

    // A same-cycle issue and response cancel out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                   out_cnt[c] <= '0;
      else if (f_pop[c] && !dec) out_cnt[c] <= out_cnt[c] + 1'b1;
      else if (dec && !f_pop[c]) out_cnt[c] <= out_cnt[c] - 1'b1;
    end

`ifdef MEM_QOS_ARB_AGING_EN
    localparam int AGE_W = $clog2(AGE_TH + 1);
    logic [AGE_W-1:0] age;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         age <= '0;
      else if (f_pop[c])                               age <= '0;
      else if (elig[c] && (age != AGE_W'(AGE_TH)))     age <= age + 1'b1;
    end

    assign eff_q[c] = (age >= AGE_W'(AGE_TH)) ? EQ_W'(QOS_AGED) : EQ_W'(head_qos);
`else
    assign eff_q[c] = EQ_W'(head_qos);
`endif
  end

  // Scan starts after the last grant; strict '>' keeps the earliest tied channel.
  always_comb begin
    grant    = '0;
    best     = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CH_W'((int'(rr_last) + 1 + i) % NCH);
      if (elig[idx] && (!any_elig || (eff_q[idx] > best))) begin
        any_elig = 1'b1;
        best     = eff_q[idx];
        grant    = idx;
      end
    end
  end

  assign load = any_elig && (!mem_valid || mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      mem_tag   <= '0;
      rr_last   <= CH_W'(NCH - 1);
    end else if (load) begin
      mem_valid <= 1'b1;
      mem_addr  <= f_head[grant][ADDR_W-1:0];
      mem_wdata <= f_head[grant][ADDR_W +: DATA_W];
      mem_write <= f_head[grant][ADDR_W + DATA_W];
      mem_tag   <= grant;
      rr_last   <= grant;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  // Responses for nonexistent channels are swallowed so they cannot wedge the bus.
  assign tag_ok         = int'(mem_resp_tag) < NCH;
  assign mem_resp_ready = tag_ok ? resp_ready[mem_resp_tag] : 1'b1;
  assign resp_data      = mem_resp_data;
  assign resp_hs        = mem_resp_valid && mem_resp_ready;

  always_comb begin
    tag_live = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if ((mem_resp_tag == CH_W'(c)) && (out_cnt[c] != '0)) tag_live = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      resp_err <= 1'b0;
    else if (resp_hs && !tag_live) resp_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_qos_arb.sv
// tb/tb_mem_qos_arb.sv - scoreboard bench for mem_qos_arb
module tb_mem_qos_arb;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int NCH     = 4;
  localparam int DEPTH   = 8;
  localparam int MAX_OUT = 2;
  localparam int AGE_TH  = 4;
  localparam int CH_W    = 2;
  localparam int OUT_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_ready;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH-1:0]        req_write;
  logic [NCH*DATA_W-1:0] req_wdata;
  logic [NCH*4-1:0]      req_qos;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_write;
  logic [DATA_W-1:0]     mem_wdata;
  logic [CH_W-1:0]       mem_tag;
  logic                  mem_resp_valid;
  logic [CH_W-1:0]       mem_resp_tag;
  logic [DATA_W-1:0]     mem_resp_data;
  logic                  mem_resp_ready;
  logic [NCH-1:0]        resp_valid;
  logic [DATA_W-1:0]     resp_data;
  logic [NCH-1:0]        resp_ready;
  logic [NCH*OUT_W-1:0]  outstanding;
  logic                  resp_err;

  always #5 clk = ~clk;

  mem_qos_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH),
    .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .AGE_TH(AGE_TH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_qos(req_qos),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_tag(mem_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  int total = 0;
  int bad   = 0;
  logic [CH_W-1:0]   exp_tag_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];
  int model_out [NCH];
  int tag_hits  [NCH];
  bit sb_on = 1'b1;

  // Issue handshakes complete on the next rising edge; judge them mid-cycle.
  always @(negedge clk) begin
    logic [CH_W-1:0]   et;
    logic [ADDR_W-1:0] ea;
    if (!rst && mem_valid && mem_ready) begin
      model_out[mem_tag]++;
      tag_hits[mem_tag]++;
      if (sb_on) begin
        total++;
        if (exp_tag_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected: got tag=%0d addr=%h, required nothing", mem_tag, mem_addr);
        end else begin
          et = exp_tag_q.pop_front();
          ea = exp_addr_q.pop_front();
          if (mem_tag !== et || mem_addr !== ea) begin
            bad++;
            $display("FAIL issue_order: got tag=%0d addr=%h, required tag=%0d addr=%h",
                     mem_tag, mem_addr, et, ea);
          end
        end
      end
    end
    if (!rst && mem_resp_valid && mem_resp_ready && model_out[mem_resp_tag] > 0)
      model_out[mem_resp_tag]--;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic drive_req(input int ch, input logic [ADDR_W-1:0] addr, input logic [3:0] qos);
    req_valid[ch] = 1'b1;
    req_addr[ch*ADDR_W +: ADDR_W] = addr;
    req_qos[ch*4 +: 4] = qos;
    req_write[ch] = addr[0];
    req_wdata[ch*DATA_W +: DATA_W] = {16'hD000, addr};
  endtask

  task automatic expect_issue(input int ch, input logic [ADDR_W-1:0] addr);
    exp_tag_q.push_back(CH_W'(ch));
    exp_addr_q.push_back(addr);
  endtask

  task automatic clear_model();
    exp_tag_q.delete();
    exp_addr_q.delete();
    for (int c = 0; c < NCH; c++) model_out[c] = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
  endtask

  // Keeps answering issued requests until every expected issue has been seen.
  task automatic drain(input string name);
    int  n;
    int  pick;
    bit  done;
    n = 0;
    done = 1'b0;
    mem_ready = 1'b1;
    while (!done && n < 300) begin
      pick = -1;
      for (int c = 0; c < NCH; c++) if (pick < 0 && model_out[c] > 0) pick = c;
      if (pick >= 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_tag = CH_W'(pick);
      end else begin
        mem_resp_valid = 1'b0;
      end
      if (pick < 0 && exp_tag_q.size() == 0 && !mem_valid) done = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    mem_resp_valid = 1'b0;
    total++;
    if (!done || outstanding !== '0) begin
      bad++;
      $display("FAIL drain_%s: done=%0d outstanding=%h, required done=1 outstanding=0",
               name, done, outstanding);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    req_addr = '0; req_write = '0; req_wdata = '0; req_qos = '0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0;
    mem_resp_data = '0; resp_ready = '1;
    clear_model();
    for (int c = 0; c < NCH; c++) tag_hits[c] = 0;
    repeat (3) tick();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid: got %b required 0", mem_valid); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
    total++; if (outstanding !== '0) begin bad++; $display("FAIL reset_outstanding: got %h required 0", outstanding); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err: got %b required 0", resp_err); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 4'hF) begin bad++; $display("FAIL release_req_ready: got %b required 1111", req_ready); end
  endtask

  task automatic test_single_latency();
    mem_ready = 1'b1;
    drive_req(0, 16'h0101, 4'd5);
    expect_issue(0, 16'h0101);
    tick();
    idle();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL latency_cycle1: mem_valid=%b required 0", mem_valid); end
    tick();
    total++;
    if (mem_valid !== 1'b1 || mem_tag !== 2'd0 || mem_write !== 1'b1 || mem_wdata !== 32'hD0000101) begin
      bad++;
      $display("FAIL latency_cycle2: valid=%b tag=%0d write=%b wdata=%h required 1 0 1 d0000101",
               mem_valid, mem_tag, mem_write, mem_wdata);
    end
    total++; if (outstanding[0 +: OUT_W] !== 2'd1) begin bad++; $display("FAIL single_outstanding: got %0d required 1", outstanding[0 +: OUT_W]); end
    drain("single");
  endtask

  task automatic test_qos_priority();
    mem_ready = 1'b1;
    drive_req(1, 16'h1100, 4'd3);
    drive_req(2, 16'h2200, 4'd9);
    expect_issue(2, 16'h2200);
    expect_issue(1, 16'h1100);
    tick();
    idle();
    drain("qos");
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < NCH; c++) drive_req(c, ADDR_W'(16'h4000 + c * 16), 4'd7);
    tick();
    for (int c = 0; c < NCH; c++) drive_req(c, ADDR_W'(16'h4001 + c * 16), 4'd7);
    tick();
    idle();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) expect_issue(c, ADDR_W'(16'h4000 + r + c * 16));
    for (int i = 0; i < 2 * NCH; i++) begin
      total++;
      if (mem_valid !== 1'b1) begin bad++; $display("FAIL b2b_bubble: cycle %0d mem_valid=%b required 1", i, mem_valid); end
      tick();
    end
    total++; if (exp_tag_q.size() != 0) begin bad++; $display("FAIL b2b_count: %0d left required 0", exp_tag_q.size()); end
    total++; if (outstanding !== 8'hAA) begin bad++; $display("FAIL b2b_outstanding: got %h required aa", outstanding); end
    drain("b2b");
  endtask

  task automatic test_max_out();
    int n;
    mem_ready = 1'b1;
    drive_req(0, 16'h0A00, 4'd15); expect_issue(0, 16'h0A00); tick();
    drive_req(0, 16'h0A02, 4'd15); expect_issue(0, 16'h0A02); tick();
    idle();
    n = 0;
    while (model_out[0] != 2 && n < 10) begin tick(); n++; end
    total++; if (model_out[0] != 2) begin bad++; $display("FAIL maxout_fill: issued %0d required 2", model_out[0]); end
    drive_req(0, 16'h0A04, 4'd15);
    drive_req(1, 16'h1B00, 4'd0);
    expect_issue(1, 16'h1B00);
    tick();
    idle();
    repeat (5) tick();
    total++; if (exp_tag_q.size() != 0) begin bad++; $display("FAIL maxout_ch1_issued: %0d left required 0", exp_tag_q.size()); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL maxout_ch0_blocked: mem_valid=%b required 0", mem_valid); end
    total++; if (outstanding[0 +: OUT_W] !== 2'd2) begin bad++; $display("FAIL maxout_count: got %0d required 2", outstanding[0 +: OUT_W]); end
    expect_issue(0, 16'h0A04);
    mem_resp_valid = 1'b1; mem_resp_tag = 2'd0;
    tick();
    mem_resp_valid = 1'b0;
    n = 0;
    while (exp_tag_q.size() != 0 && n < 8) begin tick(); n++; end
    total++; if (exp_tag_q.size() != 0) begin bad++; $display("FAIL maxout_resume: %0d left required 0", exp_tag_q.size()); end
    drain("maxout");
  endtask

  task automatic test_full_fifo();
    mem_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      drive_req(0, ADDR_W'(16'h0C00 + i), 4'd1);
      expect_issue(0, ADDR_W'(16'h0C00 + i));
      tick();
    end
    idle();
    total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL fifo_full_ready: got %b required 0", req_ready[0]); end
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 16'h0C00) begin
      bad++;
      $display("FAIL hold_stable: valid=%b addr=%h required 1 0c00", mem_valid, mem_addr);
    end
    mem_ready = 1'b1;
    drive_req(0, 16'h0C09, 4'd1);
    total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL full_pop_ready: got %b required 0", req_ready[0]); end
    tick();
    idle();
    mem_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_tag = 2'd0;
    tick();
    mem_resp_valid = 1'b0;
    mem_ready = 1'b1;
    drive_req(0, 16'h0C09, 4'd1);
    expect_issue(0, 16'h0C09);
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL push_pop_ready: got %b required 1", req_ready[0]); end
    tick();
    idle();
    drain("full");
  endtask

  task automatic test_resp_err();
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL err_pre: got %b required 0", resp_err); end
    mem_resp_valid = 1'b1;
    mem_resp_tag = 2'd1;
    mem_resp_data = 32'hDEADBEEF;
    #1;
    total++; if (resp_valid !== 4'b0010) begin bad++; $display("FAIL route_valid: got %b required 0010", resp_valid); end
    total++; if (resp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL route_data: got %h required deadbeef", resp_data); end
    tick();
    mem_resp_valid = 1'b0;
    total++; if (outstanding !== '0) begin bad++; $display("FAIL err_outstanding: got %h required 0", outstanding); end
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b required 1", resp_err); end
  endtask

  task automatic test_reset_mid_burst();
    mem_ready = 1'b0;
    drive_req(1, 16'h5100, 4'd2);
    drive_req(2, 16'h5200, 4'd2);
    drive_req(3, 16'h5300, 4'd2);
    tick();
    tick();
    idle();
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL burst_pre_valid: got %b required 1", mem_valid); end
    #1;
    rst = 1'b1;
    clear_model();
    #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b required 0", mem_valid); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_mid_ready: got %b required 0000", req_ready); end
    total++; if (outstanding !== '0) begin bad++; $display("FAIL rst_mid_outstanding: got %h required 0", outstanding); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_mid_err: got %b required 0", resp_err); end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (3) tick();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_discard: mem_valid=%b required 0", mem_valid); end
    mem_resp_valid = 1'b1;
    mem_resp_tag = 2'd2;
    tick();
    mem_resp_valid = 1'b0;
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL late_resp_err: got %b required 1", resp_err); end
    pulse_reset();
  endtask

`ifdef MEM_QOS_ARB_AGING_EN
  task automatic test_aging();
    int n;
    sb_on = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < NCH; c++) tag_hits[c] = 0;
    drive_req(3, 16'h3300, 4'd0);
    drive_req(0, 16'h0E00, 4'd15);
    n = 0;
    while (tag_hits[3] == 0 && n < 12) begin
      mem_resp_valid = (model_out[0] > 0);
      mem_resp_tag = 2'd0;
      tick();
      req_valid[3] = 1'b0;
      n++;
    end
    idle();
    mem_resp_valid = 1'b0;
    total++; if (tag_hits[3] == 0) begin bad++; $display("FAIL aging_grant: ch3 not issued in %0d cycles", n); end
    drain("aging");
    sb_on = 1'b1;
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single_latency();
    test_qos_priority();
    test_back_to_back();
    test_max_out();
    test_full_fifo();
    test_resp_err();
    test_reset_mid_burst();
`ifdef MEM_QOS_ARB_AGING_EN
    test_aging();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_qos_arb.md
MEM_QOS_ARB -- requirements
Module: mem_qos_arb

Interface
REQ-001 SHALL expose parameters, one per line: name, default, meaning.
- ADDR_W, 48, address width.
- DATA_W, 256, data width.
- NCH, 4, request channels.
- DEPTH, 8, per-channel FIFO entries (power of 2).
- MAX_OUT, 16, per-channel outstanding limit.
- AGE_TH, 64, starvation threshold in cycles.
REQ-002 SHALL expose ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, NCH, per-channel request valid.
- req_ready, out, NCH, per-channel accept.
- req_addr, in, NCH*ADDR_W, packed addresses.
- req_write, in, NCH, 1=write.
- req_wdata, in, NCH*DATA_W, packed write data.
- req_qos, in, NCH*4, packed priority, 15 highest.
- mem_valid, out, 1, downstream request valid.
- mem_ready, in, 1, downstream accept.
- mem_addr, out, ADDR_W, downstream address.
- mem_write, out, 1, downstream write flag.
- mem_wdata, out, DATA_W, downstream write data.
- mem_tag, out, CH_W, issuing channel; CH_W=max(1,$clog2(NCH)).
- mem_resp_valid, in, 1, response valid.
- mem_resp_tag, in, CH_W, response channel.
- mem_resp_data, in, DATA_W, response data.
- mem_resp_ready, out, 1, response accept.
- resp_valid, out, NCH, per-channel response valid.
- resp_data, out, DATA_W, shared response data.
- resp_ready, in, NCH, per-channel response accept.
- outstanding, out, NCH*OUT_W, per-channel counts; OUT_W=$clog2(MAX_OUT+1).
- resp_err, out, 1, sticky error flag.

Function
REQ-003 SHALL buffer each channel in its own FIFO; req_ready[c] = !rst && FIFO c not full; push on req_valid[c]&&req_ready[c].
REQ-004 SHALL treat channel c as eligible when its FIFO is non-empty and outstanding[c] < MAX_OUT.
REQ-005 SHALL load the output register when it is empty or mem_valid&&mem_ready in the same cycle (back-to-back issue, no bubble).
REQ-006 SHALL select the eligible channel with the highest effective QoS; ties SHALL resolve round-robin starting at the channel after the last grant.
REQ-007 SHALL hold mem_valid/addr/write/wdata/tag stable until mem_ready.
REQ-008 SHALL give a minimum latency of 2 cycles from req handshake edge to mem_valid high.
REQ-009 SHALL increment outstanding[c] when channel c is loaded into the output register and decrement on resp handshake for tag c; simultaneous increment and decrement for c SHALL leave it unchanged.
REQ-010 SHALL route responses combinationally:
- resp_valid[c] = mem_resp_valid && mem_resp_tag==c.
- resp_data = mem_resp_data.
- mem_resp_ready = resp_ready[mem_resp_tag].
REQ-011 SHALL NOT decrement on a response whose tag has outstanding==0 or tag>=NCH; it SHALL set resp_err until reset.
REQ-012 SHALL accept simultaneous push to a full-minus-one FIFO and pop from the same FIFO without loss; a full FIFO with a same-cycle pop SHALL still deassert req_ready (no pass-through).
REQ-013 SHALL wrap FIFO pointers modulo DEPTH.

Reset
REQ-014 SHALL, on rst assertion, asynchronously clear FIFOs, the output register, counters, the RR pointer, age counters and resp_err.
REQ-015 SHALL drive mem_valid=0, req_ready=0, outstanding=0 and resp_err=0 while rst is high; in-flight requests SHALL be discarded and responses arriving after reset SHALL set resp_err.

Configuration
REQ-016 SHALL, with MEM_QOS_ARB_AGING_EN defined:
- Keep a saturating per-channel age counter, incremented each cycle the channel is eligible but not granted and cleared on grant.
- Raise effective QoS to 16 when age >= AGE_TH; multiple aged channels SHALL tie-break round-robin.
REQ-017 SHALL, without the macro, omit age logic; effective QoS = req_qos of the FIFO head.

Structure
REQ-018 SHALL place the qos_t (4-bit) type, the QOS_AGED constant (16) and the CH_W/OUT_W helper functions in package mem_qos_arb_pkg.
REQ-019 SHALL instantiate NCH copies of sub-module mem_qos_arb_fifo (storing addr, write, wdata, qos) with push/pop, full, empty and head outputs.

Verification
REQ-020 Single write on ch0 at cycle 0 -> mem_valid at cycle 2, mem_tag=0, outstanding[0]=1.
REQ-021 ch1 qos=3 and ch2 qos=9 pending together -> ch2 issued first, then ch1.
REQ-022 Four channels, equal qos, mem_ready=1 -> issue order 0,1,2,3,0… with no idle cycles.
REQ-023 MAX_OUT=2, ch0 issues 2, no response -> ch0 blocked while ch1 issues; one ch0 response -> ch0 resumes.
REQ-024 Aging enabled, AGE_TH=4, ch3 qos=0 vs ch0 qos=15 saturating -> ch3 granted after at most 5 cycles.
REQ-025 Response tag=1 with outstanding[1]=0 -> outstanding unchanged, resp_err=1; rst mid-burst -> all outputs 0 the same cycle.
